// File: rtl/regfile_ctrl.sv
// 31x32 register file with r0 hardwired to zero and a post-reset clear sweep (one register per cycle).
// Optional write-through forwarding of the write port onto both read ports: define REGFILE_BYPASS_EN.
module regfile_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [4:0]  a3,
  input  logic        we3,
  input  logic [31:0] wd3,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic        ready
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t      state_reg;
  logic [4:0]  clrptr_reg;
  logic        ready_reg;

  logic [31:0] mem [1:31];

  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  // The sweep and the user write share one write port; they never overlap in time.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = a3;
    wr_data = wd3;
    if (rst_n) begin
      if (state_reg == CLEAR) begin
        wr_en   = (clrptr_reg != 5'd0);
        wr_addr = clrptr_reg;
        wr_data = 32'h0;
      end else if (we3 && (a3 != 5'd0)) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= CLEAR;
      clrptr_reg <= 5'd1;
      ready_reg  <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          if (clrptr_reg == 5'd31) begin
            state_reg <= READY;
            ready_reg <= 1'b1;
          end else begin
            clrptr_reg <= clrptr_reg + 5'd1;
          end
        end
        READY: begin
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg  <= CLEAR;
          clrptr_reg <= 5'd1;
          ready_reg  <= 1'b0;
        end
      endcase
    end
  end

  logic        fwd1;
  logic        fwd2;
  logic [31:0] raw1;
  logic [31:0] raw2;

`ifdef REGFILE_BYPASS_EN
  assign fwd1 = ready_reg && we3 && (a3 != 5'd0) && (a1 == a3);
  assign fwd2 = ready_reg && we3 && (a3 != 5'd0) && (a2 == a3);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // Reads are forced to zero until the sweep finishes so no stale contents leak out.
  always_comb begin
    raw1 = 32'h0;
    raw2 = 32'h0;
    if (ready_reg && (a1 != 5'd0)) raw1 = mem[a1];
    if (ready_reg && (a2 != 5'd0)) raw2 = mem[a2];
  end

  assign rd1   = fwd1 ? wd3 : raw1;
  assign rd2   = fwd2 ? wd3 : raw2;
  assign ready = ready_reg;

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
- REQ-001: clk  input  1  Single clock; all state updates on the rising edge.
- REQ-002: rst_n  input  1  Reset, synchronous and active-low.
- REQ-003: a1  input  5  Read-port-1 register index; selects the value driven on rd1, which feeds ALU srca.
- REQ-004: a2  input  5  Read-port-2 register index; selects the value driven on rd2, which feeds the srcb mux.
- REQ-005: a3  input  5  Write-port register index.
- REQ-006: we3  input  1  Write enable for the write port.
- REQ-007: wd3  input  32  Write data, taken from aluresult or memory read data.
- REQ-008: rd1  output  32  Read data, port 1.
- REQ-009: rd2  output  32  Read data, port 2.
- REQ-010: ready  output  1  High once the clear sweep is complete and the file is usable.

Function
- REQ-011: Storage SHALL be 31 physical 32-bit registers, r1..r31.
- REQ-012: r0 SHALL read as 32'h0 at all times, and writes to a3==0 SHALL be discarded.
- REQ-013: Reads SHALL be combinational.
  - rd1 = reg[a1] and rd2 = reg[a2], zero latency.
  - Both ports are independent; a1==a2 is legal.
- REQ-014: Writes SHALL occur at the rising edge when we3=1, ready=1 and a3!=0; the new value is visible on rd1/rd2 after that edge.
- REQ-015: The FSM SHALL have two states, CLEAR and READY, with a 5-bit clear pointer clrptr.
- REQ-016: CLEAR state behaviour:
  - On each edge with rst_n=1, reg[clrptr]<=0.
  - If clrptr==31, the next state is READY; otherwise clrptr increments.
- REQ-017: While in CLEAR, we3 SHALL be ignored, rd1/rd2 SHALL output 32'h0, and ready SHALL be 0.
- REQ-018: READY SHALL be absorbing until rst_n=0, and ready SHALL be 1 in READY.
- REQ-019: ready SHALL first read 1 exactly 31 rising edges after the first edge with rst_n=1.
- REQ-020: Reset asserted mid-sweep or while in READY SHALL restart the sweep from clrptr=1; any write presented in the same cycle is dropped.
- REQ-021: A simultaneous write and read of the same index SHALL follow the macro-dependent behaviour in REQ-026/REQ-027.
- REQ-022: A read of an index whose clear is not yet complete SHALL never expose stale data, which REQ-017 guarantees.

Reset
- REQ-023: On an edge with rst_n=0, the state SHALL become CLEAR, clrptr SHALL become 5'd1, and ready SHALL become 0.
- REQ-024: Register contents SHALL NOT be reset directly; zeroing occurs only through the sweep, one register per cycle.
- REQ-025: There SHALL be no asynchronous path from rst_n to any flop.

Configuration
- REQ-026: With REGFILE_BYPASS_EN defined, write-through forwarding SHALL apply:
  - Condition: ready=1, we3=1, a3!=0 and a1==a3.
  - Result: rd1=wd3 combinationally in the same cycle.
  - rd2 is forwarded identically when a2==a3.
- REQ-027: With REGFILE_BYPASS_EN undefined, rd1/rd2 SHALL show the old register value until after the write edge.

Verification
- REQ-028: Sweep timing: hold rst_n=0 for 3 edges, then release.
  - ready=0 for 30 edges and 1 from edge 31.
  - rd1 for a1=1..31 reads 32'h0 once ready=1.
- REQ-029: Write then read: write r5=32'hDEAD_BEEF, then set a1=5, a2=5.
  - Both rd1 and rd2 read 32'hDEAD_BEEF the cycle after the write edge.
- REQ-030: r0 protection: write a3=0, wd3=32'hFFFF_FFFF, we3=1.
  - rd1 with a1=0 reads 32'h0.
- REQ-031: Write during CLEAR: present we3=1, a3=7, wd3=32'h1234 while ready=0.
  - After ready=1, r7 reads 32'h0.
- REQ-032: Same-cycle write/read: write r9=32'hA5A5_A5A5 while a1=9 and r9 holds 32'h1.
  - Pre-edge rd1 reads 32'hA5A5_A5A5 with REGFILE_BYPASS_EN defined.
  - Pre-edge rd1 reads 32'h1 with it undefined.
- REQ-033: Mid-operation reset: with r3=32'h55 in READY, pulse rst_n=0 for one edge.
  - ready drops to 0 and reasserts 31 edges later.
  - r3 then reads 32'h0.
